// File: rtl/bl_wl_config_writer.sv
// Memory-bank configuration writer: drives a BL word and one WL pulse per frame.
// Optional even-parity check on frame_bl when BL_WL_PARITY_EN is defined.
module bl_wl_config_writer #(
    parameter int BL_WIDTH     = 8,
    parameter int WL_WIDTH     = 8,
    parameter int WL_ADDR_W    = 3,
    parameter int PULSE_CYCLES = 2
) (
    input  logic                   prog_clk,
    input  logic                   pReset,
    input  logic                   frame_valid,
    output logic                   frame_ready,
    input  logic [0:BL_WIDTH-1]    frame_bl,
    input  logic [0:WL_ADDR_W-1]   frame_wl_addr,
    input  logic                   frame_last,
`ifdef BL_WL_PARITY_EN
    input  logic                   frame_parity,
`endif
    output logic [0:BL_WIDTH-1]    bl,
    output logic [0:WL_WIDTH-1]    wl,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [15:0]            frame_count
);

    localparam int CNT_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [0:BL_WIDTH-1]    r_bl;
    logic [0:WL_WIDTH-1]    r_wl;
    logic [0:WL_ADDR_W-1]   r_row;
    logic                   r_last;
    logic                   r_done;
    logic                   r_err;
    logic [15:0]            r_count;
    logic [CNT_W-1:0]       r_cnt;
    logic [0:WL_WIDTH-1]    w_onehot;
    logic                   w_accept;
    logic                   w_bad_addr;
    logic                   w_bad_par;
    logic                   w_drop;

    assign w_accept   = frame_valid && (r_state == S_IDLE) && !r_done;
    assign w_bad_addr = (32'(frame_wl_addr) >= 32'(WL_WIDTH));
`ifdef BL_WL_PARITY_EN
    assign w_bad_par  = ((^frame_bl) != frame_parity);
`else
    assign w_bad_par  = 1'b0;
`endif
    assign w_drop     = w_bad_addr || w_bad_par;

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < WL_WIDTH; i++) begin
            w_onehot[i] = (r_row == WL_ADDR_W'(i));
        end
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept && !w_drop) w_next = S_SETUP;
            S_SETUP: w_next = S_PULSE;
            S_PULSE: if (r_cnt == '0) w_next = S_HOLD;
            S_HOLD:  w_next = S_IDLE;
        endcase
    end

    // WL is set/cleared on state edges so it stays a clean registered one-hot.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_bl    <= '0;
            r_wl    <= '0;
            r_row   <= '0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_count <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_accept && !w_drop) begin
                r_bl   <= frame_bl;
                r_row  <= frame_wl_addr;
                r_last <= frame_last;
            end
            if (w_accept && w_drop) begin
                r_err <= 1'b1;
            end
            unique case (r_state)
                S_SETUP: begin
                    r_cnt <= CNT_W'(PULSE_CYCLES - 1);
                    r_wl  <= w_onehot;
                end
                S_PULSE: begin
                    if (r_cnt == '0) begin
                        r_wl <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
                    if (r_last) r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bl          = r_bl;
    assign wl          = r_wl;
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign err         = r_err;
    assign frame_count = r_count;
    assign frame_ready = (r_state == S_IDLE) && !r_done;

endmodule

// File: tb/tb_bl_wl_config_writer.sv
// Directed vector bench for bl_wl_config_writer (BL 8, WL 8, 4-bit row, 2-cycle pulse).
module tb_bl_wl_config_writer;

    localparam int PC = 2;
`ifdef BL_WL_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk;
    logic        pReset;
    logic        frame_valid;
    logic        frame_ready;
    logic [0:7]  frame_bl;
    logic [0:3]  frame_wl_addr;
    logic        frame_last;
    logic        frame_parity;
    logic [0:7]  bl;
    logic [0:7]  wl;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] frame_count;

    bl_wl_config_writer #(
        .BL_WIDTH(8), .WL_WIDTH(8), .WL_ADDR_W(4), .PULSE_CYCLES(PC)
    ) dut (
        .prog_clk(clk),
        .pReset(pReset),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .frame_bl(frame_bl),
        .frame_wl_addr(frame_wl_addr),
        .frame_last(frame_last),
`ifdef BL_WL_PARITY_EN
        .frame_parity(frame_parity),
`endif
        .bl(bl),
        .wl(wl),
        .busy(busy),
        .done(done),
        .err(err),
        .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [7:0]  m_bl;
    logic [15:0] m_cnt;
    logic        m_err;
    logic        m_done;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] bl;
        logic [3:0] addr;
        bit         bad_par;
        logic [7:0] exp_wl;
        bit         exp_drop;
    } vec_t;

    vec_t vt[10];

    task automatic run_frame(input logic [7:0] vbl, input logic [3:0] vaddr,
                             input bit vlast, input bit vbadp,
                             input logic [7:0] ewl, input bit edrop);
        int k;
        frame_bl      = vbl;
        frame_wl_addr = vaddr;
        frame_last    = vlast;
        frame_parity  = (^vbl) ^ vbadp;
        frame_valid   = 1'b1;
        k = 0;
        while (!frame_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("ready_wait", 32'(frame_ready), 32'd1);
        if (!frame_ready) begin
            frame_valid = 1'b0;
            return;
        end
        @(negedge clk);
        frame_valid = 1'b0;
        if (edrop) begin
            m_err = 1'b1;
            chk("drop_err", 32'(err), 32'd1);
            chk("drop_wl", 32'(wl), 32'd0);
            chk("drop_busy", 32'(busy), 32'd0);
            chk("drop_bl", 32'(bl), 32'(m_bl));
            chk("drop_cnt", 32'(frame_count), 32'(m_cnt));
            chk("drop_ready", 32'(frame_ready), 32'd1);
        end else begin
            m_bl = vbl;
            chk("setup_bl", 32'(bl), 32'(m_bl));
            chk("setup_wl", 32'(wl), 32'd0);
            chk("setup_busy", 32'(busy), 32'd1);
            chk("setup_ready", 32'(frame_ready), 32'd0);
            repeat (PC) begin
                @(negedge clk);
                chk("pulse_wl", 32'(wl), 32'(ewl));
                chk("pulse_bl", 32'(bl), 32'(m_bl));
            end
            @(negedge clk);
            chk("hold_wl", 32'(wl), 32'd0);
            chk("hold_busy", 32'(busy), 32'd1);
            chk("hold_bl", 32'(bl), 32'(m_bl));
            @(negedge clk);
            if (vlast) m_done = 1'b1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            chk("post_busy", 32'(busy), 32'd0);
            chk("post_cnt", 32'(frame_count), 32'(m_cnt));
            chk("post_done", 32'(done), 32'(m_done));
            chk("post_ready", 32'(frame_ready), 32'(!m_done));
        end
        chk("err_sticky", 32'(err), 32'(m_err));
    endtask

    initial begin
        int order[$];
        int multi;
        int r;
        int k;
        logic prev_busy;
        logic [7:0] prev_wl;

        vt[0] = '{8'hA5, 4'd3,  1'b0, 8'b0001_0000, 1'b0};
        vt[1] = '{8'h3C, 4'd0,  1'b0, 8'b1000_0000, 1'b0};
        vt[2] = '{8'hFF, 4'd7,  1'b0, 8'b0000_0001, 1'b0};
        vt[3] = '{8'h12, 4'd9,  1'b0, 8'b0000_0000, 1'b1};
        vt[4] = '{8'h5A, 4'd3,  1'b0, 8'b0001_0000, 1'b0};
        vt[5] = '{8'h81, 4'd3,  1'b0, 8'b0001_0000, 1'b0};
        vt[6] = '{8'h01, 4'd5,  1'b1, 8'b0000_0100, 1'b0};
        vt[7] = '{8'h01, 4'd5,  1'b0, 8'b0000_0100, 1'b0};
        vt[8] = '{8'h66, 4'd15, 1'b0, 8'b0000_0000, 1'b1};
        vt[9] = '{8'h00, 4'd8,  1'b0, 8'b0000_0000, 1'b1};

        pReset = 1'b1;
        frame_valid = 1'b0;
        frame_bl = '0;
        frame_wl_addr = '0;
        frame_last = 1'b0;
        frame_parity = 1'b0;
        m_bl = '0; m_cnt = '0; m_err = 1'b0; m_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_bl", 32'(bl), 32'd0);
        chk("rst_wl", 32'(wl), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cnt", 32'(frame_count), 32'd0);
        pReset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(frame_ready), 32'd1);

        for (int i = 0; i < 10; i++) begin
            run_frame(vt[i].bl, vt[i].addr, 1'b0, vt[i].bad_par, vt[i].exp_wl,
                      vt[i].exp_drop || (PAR_EN && vt[i].bad_par));
        end

        // Reset during the second pulse cycle of a row-6 write.
        frame_bl = 8'hC3; frame_wl_addr = 4'd6; frame_last = 1'b0;
        frame_parity = ^8'hC3; frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        @(negedge clk);
        chk("mid_pulse1", 32'(wl), 32'h02);
        @(negedge clk);
        chk("mid_pulse2", 32'(wl), 32'h02);
        #1 pReset = 1'b1;
        #1;
        chk("mid_rst_wl", 32'(wl), 32'd0);
        chk("mid_rst_bl", 32'(bl), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_cnt", 32'(frame_count), 32'd0);
        m_bl = '0; m_cnt = '0; m_err = 1'b0; m_done = 1'b0;
        @(negedge clk);
        pReset = 1'b0;
        @(negedge clk);
        chk("mid_rel_ready", 32'(frame_ready), 32'd1);
        run_frame(8'h77, 4'd2, 1'b0, 1'b0, 8'b0010_0000, 1'b0);

        // Back-to-back rows 0..7 with frame_valid held high, last on row 7.
        order = {};
        multi = 0;
        r = 0;
        prev_busy = 1'b0;
        prev_wl = '0;
        frame_bl = 8'h10; frame_wl_addr = 4'd0; frame_last = 1'b0;
        frame_parity = ^8'h10; frame_valid = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if ($countones(wl) > 1) multi++;
            if (wl != 8'h00 && wl != prev_wl) begin
                for (int j = 0; j < 8; j++) if (wl[j]) order.push_back(j);
            end
            prev_wl = wl;
            if (busy && !prev_busy) begin
                r++;
                frame_bl      = 8'(8'h10 + r);
                frame_wl_addr = 4'(r % 8);
                frame_last    = (r == 7);
                frame_parity  = ^(8'(8'h10 + r));
            end
            prev_busy = busy;
        end
        m_cnt = m_cnt + 16'd8;
        chk("b2b_n", 32'(order.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            k = (order.size() > i) ? order[i] : -1;
            chk("b2b_row", 32'(k), 32'(i));
        end
        chk("b2b_onehot", 32'(multi), 32'd0);
        chk("b2b_done", 32'(done), 32'd1);
        chk("b2b_cnt", 32'(frame_count), 32'(m_cnt));
        chk("b2b_ready", 32'(frame_ready), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd0);
        chk("b2b_bl", 32'(bl), 32'h17);
        frame_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
